// File: rtl/branch_predictor_pkg.sv
// Shared types for the bimodal branch predictor: counter, queue entry and FSM state.
// The counter update rule lives here so the table and any model agree on saturation.
package branch_predictor_pkg;

    localparam int CRAM_ADDR_W = 16;
    localparam int BP_IDX_W    = 8;

    typedef logic [1:0] bp_ctr_t;

    localparam bp_ctr_t BP_CTR_INIT = 2'b01;

    typedef struct packed {
        logic [BP_IDX_W-1:0] idx;
        logic                pred;
    } bp_entry_t;

    typedef enum logic {
        BP_INIT,
        BP_RUN
    } bp_state_t;

    // Two-bit saturating step: taken climbs toward 3, not-taken falls toward 0.
    function automatic bp_ctr_t bp_ctr_next(input bp_ctr_t ctr, input logic taken);
        bp_ctr_t nxt;
        nxt = ctr;
        if (taken && ctr != 2'b11) begin
            nxt = ctr + 2'd1;
        end else if (!taken && ctr != 2'b00) begin
            nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bp_queue.sv
// In-order queue of outstanding predictions. A flush keeps the current pop and
// discards everything younger by snapping the tail onto the advanced head.
module bp_queue #(
    parameter int  DATA_W = 9,
    parameter int  DEPTH  = 4,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = AW + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic [CW-1:0]     count_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     head_q, head_d;
    logic [AW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;

    always_comb begin
        head_d  = pop_i  ? head_q + AW'(1) : head_q;
        tail_d  = push_i ? tail_q + AW'(1) : tail_q;
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (flush_i) begin
            tail_d  = head_d;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i && !rst_i) begin
            mem_q[tail_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[head_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: 2-bit counter table indexed by word PC, answered
// combinationally, trained in order from a queue of outstanding predictions.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int      BHT_IDX_W  = BP_IDX_W,
    parameter int      FIFO_DEPTH = 4,
    parameter bp_ctr_t CTR_INIT   = BP_CTR_INIT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    input  logic                   lookup_valid,
    input  logic [CRAM_ADDR_W-1:0] lookup_pc,
    input  logic                   lookup_is_branch,
    output logic                   take_flag,
    input  logic                   resolve_valid,
    input  logic                   resolve_taken,
    input  logic                   resolve_miss,
    output logic                   bp_ready,
    output logic                   bp_full,
    output logic                   err_overflow,
    output logic                   err_underflow,
    output logic [31:0]            stat_pred,
    output logic [31:0]            stat_miss,
    output bp_state_t              dbg_state
);

    localparam int ENTRIES = 1 << BHT_IDX_W;
    localparam int CW      = $clog2(FIFO_DEPTH) + 1;

    bp_ctr_t               bht_q [ENTRIES];
    bp_state_t             state_q;
    logic [BHT_IDX_W-1:0]  ptr_q;
    logic                  bp_ready_q, err_overflow_q, err_underflow_q;
    logic [31:0]           stat_pred_q, stat_miss_q;

    logic [BHT_IDX_W-1:0]  lookup_idx;
    bp_entry_t             push_entry, head_entry;
    logic [CW-1:0]         q_count;
    logic                  q_full, q_empty;
    logic                  run, push_req, pop_req, push_ok, pop_ok, flush;
    logic                  unused_bits;

    assign lookup_idx = lookup_pc[BHT_IDX_W+1:2];
    assign run        = (state_q == BP_RUN);
    assign take_flag  = run & lookup_valid & lookup_is_branch & bht_q[lookup_idx][1];

    // A mispredict marks this cycle's fetch as wrong-path, so it never enters the queue.
    assign push_req = ce & run & ~rst & lookup_valid & lookup_is_branch & ~resolve_miss;
    assign pop_req  = ce & run & ~rst & resolve_valid;
    assign pop_ok   = pop_req & ~q_empty;
    assign push_ok  = push_req & (~q_full | pop_ok);
    assign flush    = pop_ok & resolve_miss;

    assign push_entry.idx  = lookup_idx;
    assign push_entry.pred = bht_q[lookup_idx][1];

    bp_queue #(
        .DATA_W ($bits(bp_entry_t)),
        .DEPTH  (FIFO_DEPTH)
    ) u_queue (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push_ok),
        .pop_i   (pop_ok),
        .flush_i (flush),
        .wdata_i (push_entry),
        .rdata_o (head_entry),
        .count_o (q_count),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    // Single write port: the init sweep owns it in INIT, the retiring head in RUN.
    always_ff @(posedge clk) begin
        if (!run) begin
            bht_q[ptr_q] <= CTR_INIT;
        end else if (pop_ok) begin
            bht_q[head_entry.idx] <= bp_ctr_next(bht_q[head_entry.idx], resolve_taken);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BP_INIT;
            ptr_q      <= '0;
            bp_ready_q <= 1'b0;
        end else begin
            case (state_q)
                BP_INIT: begin
                    ptr_q <= ptr_q + BHT_IDX_W'(1);
                    if (ptr_q == '1) begin
                        state_q    <= BP_RUN;
                        bp_ready_q <= 1'b1;
                    end
                end
                BP_RUN: begin
                    bp_ready_q <= 1'b1;
                end
                default: begin
                    state_q <= BP_INIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_overflow_q  <= 1'b0;
            err_underflow_q <= 1'b0;
            stat_pred_q     <= '0;
            stat_miss_q     <= '0;
        end else begin
            if (push_req && !push_ok) err_overflow_q  <= 1'b1;
            if (pop_req && q_empty)   err_underflow_q <= 1'b1;
            if (push_ok)              stat_pred_q     <= stat_pred_q + 32'd1;
            if (flush)                stat_miss_q     <= stat_miss_q + 32'd1;
        end
    end

    assign bp_ready      = bp_ready_q;
    assign bp_full       = (q_count == CW'(FIFO_DEPTH));
    assign err_overflow  = err_overflow_q;
    assign err_underflow = err_underflow_q;
    assign stat_pred     = stat_pred_q;
    assign stat_miss     = stat_miss_q;
    assign dbg_state     = state_q;

    // PC alignment bits, aliased upper bits and the stored prediction are not needed here.
    assign unused_bits = ^{lookup_pc[CRAM_ADDR_W-1:BHT_IDX_W+2], lookup_pc[1:0], head_entry.pred};

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: expected predictions are queued by the driver
// and popped by a negedge monitor; status registers are compared after each edge.
module tb_branch_predictor;
    import branch_predictor_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   ce = 1'b1;
    logic                   lookup_valid = 1'b0;
    logic                   lookup_is_branch = 1'b0;
    logic [CRAM_ADDR_W-1:0] lookup_pc = '0;
    logic                   resolve_valid = 1'b0;
    logic                   resolve_taken = 1'b0;
    logic                   resolve_miss = 1'b0;
    logic                   take_flag, bp_ready, bp_full, err_overflow, err_underflow;
    logic [31:0]            stat_pred, stat_miss;
    bp_state_t              dbg_state;

    logic exp_q[$];
    logic exp_take;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_cyc;

    branch_predictor dut (
        .clk              (clk),
        .rst              (rst),
        .ce               (ce),
        .lookup_valid     (lookup_valid),
        .lookup_pc        (lookup_pc),
        .lookup_is_branch (lookup_is_branch),
        .take_flag        (take_flag),
        .resolve_valid    (resolve_valid),
        .resolve_taken    (resolve_taken),
        .resolve_miss     (resolve_miss),
        .bp_ready         (bp_ready),
        .bp_full          (bp_full),
        .err_overflow     (err_overflow),
        .err_underflow    (err_underflow),
        .stat_pred        (stat_pred),
        .stat_miss        (stat_miss),
        .dbg_state        (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (lookup_valid && lookup_is_branch) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL take_flag pc=%h: got %0b with no expected entry queued", lookup_pc, take_flag);
            end else begin
                exp_take = exp_q.pop_front();
                if (take_flag !== exp_take) begin
                    n_errors++;
                    $display("FAIL take_flag pc=%h: got %0b expected %0b", lookup_pc, take_flag, exp_take);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        ce               = 1'b1;
        lookup_valid     = 1'b0;
        lookup_is_branch = 1'b0;
        lookup_pc        = '0;
        resolve_valid    = 1'b0;
        resolve_taken    = 1'b0;
        resolve_miss     = 1'b0;
    endtask

    task automatic drive_cycle(input logic lv, input logic [CRAM_ADDR_W-1:0] pc,
                               input logic rv, input logic rt, input logic rm,
                               input logic cev, input logic exp_t);
        lookup_valid     = lv;
        lookup_is_branch = lv;
        lookup_pc        = pc;
        resolve_valid    = rv;
        resolve_taken    = rt;
        resolve_miss     = rm;
        ce               = cev;
        if (lv) exp_q.push_back(exp_t);
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic branch(input logic [CRAM_ADDR_W-1:0] pc, input logic exp_t);
        drive_cycle(1'b1, pc, 1'b0, 1'b0, 1'b0, 1'b1, exp_t);
    endtask

    task automatic peek(input logic [CRAM_ADDR_W-1:0] pc, input logic exp_t);
        drive_cycle(1'b1, pc, 1'b0, 1'b0, 1'b0, 1'b0, exp_t);
    endtask

    task automatic resolve(input logic taken, input logic miss);
        drive_cycle(1'b0, '0, 1'b1, taken, miss, 1'b1, 1'b0);
    endtask

    task automatic both(input logic [CRAM_ADDR_W-1:0] pc, input logic exp_t,
                        input logic taken, input logic miss);
        drive_cycle(1'b1, pc, 1'b1, taken, miss, 1'b1, exp_t);
    endtask

    // Counts cycles until bp_ready, with lookups and resolves present early in the sweep.
    task automatic wait_ready(input logic [CRAM_ADDR_W-1:0] pc, output int n);
        n = 0;
        lookup_valid     = 1'b1;
        lookup_is_branch = 1'b1;
        lookup_pc        = pc;
        resolve_valid    = 1'b1;
        resolve_taken    = 1'b1;
        while (!bp_ready && n < 400) begin
            if (n < 5) exp_q.push_back(1'b0);
            @(posedge clk);
            #1;
            n++;
            if (n == 5) idle();
        end
        idle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", {31'd0, bp_ready}, 32'd0);
        check("reset_full", {31'd0, bp_full}, 32'd0);
        check("reset_state", {31'd0, dbg_state}, {31'd0, BP_INIT});
        check("reset_stat_pred", stat_pred, 32'd0);
        rst = 1'b0;

        wait_ready(16'h0040, n_cyc);
        check("init_cycles", n_cyc, 32'd256);
        check("init_underflow_ignored", {31'd0, err_underflow}, 32'd0);
        check("run_state", {31'd0, dbg_state}, {31'd0, BP_RUN});
        check("init_no_push", stat_pred, 32'd0);

        for (int i = 0; i < 256; i++) peek(CRAM_ADDR_W'(i * 4), 1'b0);

        // Train pc 0x40 up to saturation, alias through 0x440, then back down.
        branch(16'h0040, 1'b0);
        resolve(1'b1, 1'b1);
        branch(16'h0040, 1'b1);
        resolve(1'b1, 1'b0);
        branch(16'h0040, 1'b1);
        resolve(1'b1, 1'b0);
        branch(16'h0440, 1'b1);
        resolve(1'b0, 1'b1);
        branch(16'h0040, 1'b1);
        both(16'h0040, 1'b1, 1'b0, 1'b1);
        peek(16'h0040, 1'b0);
        peek(16'h0044, 1'b0);
        branch(16'h0040, 1'b0);
        resolve(1'b0, 1'b0);
        branch(16'h0040, 1'b0);
        resolve(1'b0, 1'b0);
        branch(16'h0040, 1'b0);
        resolve(1'b1, 1'b1);
        peek(16'h0040, 1'b0);
        check("train_stat_pred", stat_pred, 32'd8);
        check("train_stat_miss", stat_miss, 32'd4);
        check("train_overflow", {31'd0, err_overflow}, 32'd0);

        // Fill the queue, overflow once, then push and pop together while full.
        branch(16'h0100, 1'b0);
        branch(16'h0104, 1'b0);
        branch(16'h0108, 1'b0);
        branch(16'h010C, 1'b0);
        check("full_flag", {31'd0, bp_full}, 32'd1);
        branch(16'h0110, 1'b0);
        check("overflow_flag", {31'd0, err_overflow}, 32'd1);
        check("overflow_stat_pred", stat_pred, 32'd12);
        both(16'h0114, 1'b0, 1'b1, 1'b0);
        check("full_pushpop_stat", stat_pred, 32'd13);
        check("full_pushpop_full", {31'd0, bp_full}, 32'd1);
        repeat (4) resolve(1'b1, 1'b0);
        check("drained_full", {31'd0, bp_full}, 32'd0);
        check("drained_underflow", {31'd0, err_underflow}, 32'd0);
        peek(16'h0100, 1'b1);
        peek(16'h0104, 1'b1);
        peek(16'h0108, 1'b1);
        peek(16'h010C, 1'b1);
        peek(16'h0114, 1'b1);
        peek(16'h0110, 1'b0);

        // Mispredict flush with a wrong-path branch in the same cycle.
        branch(16'h0200, 1'b0);
        branch(16'h0204, 1'b0);
        branch(16'h0208, 1'b0);
        both(16'h020C, 1'b0, 1'b1, 1'b1);
        check("flush_stat_miss", stat_miss, 32'd5);
        check("flush_stat_pred", stat_pred, 32'd16);
        peek(16'h0200, 1'b1);
        peek(16'h0204, 1'b0);
        peek(16'h0208, 1'b0);
        check("pre_underflow", {31'd0, err_underflow}, 32'd0);
        resolve(1'b1, 1'b0);
        check("underflow_flag", {31'd0, err_underflow}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("underflow_sticky", {31'd0, err_underflow}, 32'd1);
        peek(16'h0204, 1'b0);

        // ce low freezes pushes and pops but not the prediction path.
        drive_cycle(1'b1, 16'h0200, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ce_low_stat_pred", stat_pred, 32'd16);
        branch(16'h0204, 1'b0);
        drive_cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        peek(16'h0204, 1'b0);
        resolve(1'b1, 1'b0);
        peek(16'h0204, 1'b1);
        check("ce_stat_pred", stat_pred, 32'd17);
        lookup_valid = 1'b1;
        lookup_pc    = 16'h0200;
        #1;
        check("non_branch_take", {31'd0, take_flag}, 32'd0);
        @(posedge clk);
        #1;
        idle();
        check("non_branch_no_push", stat_pred, 32'd17);

        // Reset in the middle of RUN with an entry still queued.
        branch(16'h0300, 1'b0);
        check("pre_rst_stat_pred", stat_pred, 32'd18);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_ready", {31'd0, bp_ready}, 32'd0);
        check("rst_state", {31'd0, dbg_state}, {31'd0, BP_INIT});
        check("rst_stat_pred", stat_pred, 32'd0);
        check("rst_stat_miss", stat_miss, 32'd0);
        check("rst_overflow", {31'd0, err_overflow}, 32'd0);
        check("rst_underflow", {31'd0, err_underflow}, 32'd0);
        check("rst_full", {31'd0, bp_full}, 32'd0);
        wait_ready(16'h0200, n_cyc);
        check("reinit_cycles", n_cyc, 32'd256);
        peek(16'h0200, 1'b0);
        resolve(1'b1, 1'b0);
        check("rst_queue_cleared", {31'd0, err_underflow}, 32'd1);
        check("rst_queue_no_miss", stat_miss, 32'd0);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
